// File: rtl/shift_pkg.sv
// Shared types for the shift_unit slice: shift modes and sequencer states.
package shift_pkg;

    typedef enum logic [1:0] {
        LSR = 2'b00,
        LSL = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } shift_state_t;

endpackage : shift_pkg

// File: rtl/shift_counter.sv
// Loadable down-counter for the remaining shift count.
// Loads clamp to WIDTH; Zero and Last flags are decoded from the stored count.
module shift_counter #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load_En,
    input  logic [CNT_W-1:0] Load_Val,
    input  logic             Dec_En,
    output logic             Zero,
    output logic             Last
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam logic [CNT_W-1:0] NIL_CNT = CNT_W'(0);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Next count: load with clamp has priority over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (Load_En) begin
            count_d = (Load_Val > MAX_CNT) ? MAX_CNT : Load_Val;
        end else if (Dec_En && (count_q != NIL_CNT)) begin
            count_d = count_q - ONE_CNT;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q <= NIL_CNT;
        end else begin
            count_q <= count_d;
        end
    end

    assign Zero = (count_q == NIL_CNT);
    assign Last = (count_q == ONE_CNT);

endmodule : shift_counter

// File: rtl/shift_unit.sv
// WIDTH-bit shift register with a multi-cycle shift sequencer and Busy/Done handshake.
// Optional macro SHIFT_UNIT_ROTATE_EN enables rotate-right for mode 2'b11 (else it acts as LSR).
module shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  shift_mode_t      Mode,
    input  logic [CNT_W-1:0] Amount,
    input  logic             Shift_In,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    shift_state_t     state_d,     state_q;
    shift_mode_t      mode_d,      mode_q;
    logic [WIDTH-1:0] data_d,      data_q;
    logic             shift_out_d, shift_out_q;
    logic             busy_d,      busy_q;
    logic             done_d,      done_q;

    logic             cnt_load_s;
    logic             cnt_dec_s;
    logic             cnt_zero_s;
    logic             cnt_last_s;
    logic [WIDTH-1:0] shifted_s;
    logic             shifted_bit_s;

    shift_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .Clk      (Clk),
        .Reset    (Reset),
        .Load_En  (cnt_load_s),
        .Load_Val (Amount),
        .Dec_En   (cnt_dec_s),
        .Zero     (cnt_zero_s),
        .Last     (cnt_last_s)
    );

    // Single-bit shift result and the bit leaving the register, for the latched mode.
    always_comb begin
        shifted_s     = {Shift_In, data_q[WIDTH-1:1]};
        shifted_bit_s = data_q[0];
        case (mode_q)
            LSR: begin
                shifted_s     = {Shift_In, data_q[WIDTH-1:1]};
                shifted_bit_s = data_q[0];
            end
            LSL: begin
                shifted_s     = {data_q[WIDTH-2:0], Shift_In};
                shifted_bit_s = data_q[WIDTH-1];
            end
            ASR: begin
                shifted_s     = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                shifted_bit_s = data_q[0];
            end
`ifdef SHIFT_UNIT_ROTATE_EN
            ROR: begin
                shifted_s     = {data_q[0], data_q[WIDTH-1:1]};
                shifted_bit_s = data_q[0];
            end
`else
            ROR: begin
                shifted_s     = {Shift_In, data_q[WIDTH-1:1]};
                shifted_bit_s = data_q[0];
            end
`endif
            default: begin
                shifted_s     = {Shift_In, data_q[WIDTH-1:1]};
                shifted_bit_s = data_q[0];
            end
        endcase
    end

    // Sequencer next-state and register updates; Busy/Done are precomputed for the next cycle.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        data_d      = data_q;
        shift_out_d = shift_out_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Load) begin
                    data_d = D;
                end else if (Start) begin
                    mode_d = Mode;
                    if (Amount == {CNT_W{1'b0}}) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = SHIFT;
                        busy_d     = 1'b1;
                        cnt_load_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d      = shifted_s;
                shift_out_d = shifted_bit_s;
                cnt_dec_s   = 1'b1;
                // A zero count here can only come from an upset; finish rather than hang.
                if (cnt_last_s || cnt_zero_s) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            mode_q      <= LSR;
            data_q      <= {WIDTH{1'b0}};
            shift_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            shift_out_q <= shift_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign Data_Out  = data_q;
    assign Shift_Out = shift_out_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule : shift_unit

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit (WIDTH=8) against an arithmetic reference model.
module tb_shift_unit;
    import shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Load = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic             Start = 1'b0;
    shift_mode_t      Mode = LSR;
    logic [CNT_W-1:0] Amount = '0;
    logic             Shift_In = 1'b0;
    logic [WIDTH-1:0] Data_Out;
    logic             Shift_Out;
    logic             Busy;
    logic             Done;

    int checks = 0;
    int errors = 0;

    // Reference model: register value and last bit shifted out.
    int mdl_data = 0;
    int mdl_so   = 0;

    shift_unit #(.WIDTH(WIDTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (Load),
        .D         (D),
        .Start     (Start),
        .Mode      (Mode),
        .Amount    (Amount),
        .Shift_In  (Shift_In),
        .Data_Out  (Data_Out),
        .Shift_Out (Shift_Out),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One shift of the model using integer arithmetic.
    task automatic model_shift(input shift_mode_t md, input int si);
        int msb_w;
        int full;
        msb_w = 1 << (WIDTH - 1);
        full  = (1 << WIDTH) - 1;
        case (md)
            LSL: begin
                mdl_so   = (mdl_data / msb_w) % 2;
                mdl_data = ((mdl_data * 2) + si) & full;
            end
            ASR: begin
                mdl_so   = mdl_data % 2;
                mdl_data = (mdl_data / 2) + (mdl_data & msb_w);
            end
            ROR: begin
                mdl_so = mdl_data % 2;
`ifdef SHIFT_UNIT_ROTATE_EN
                mdl_data = (mdl_data / 2) + mdl_so * msb_w;
`else
                mdl_data = (mdl_data / 2) + si * msb_w;
`endif
            end
            default: begin
                mdl_so   = mdl_data % 2;
                mdl_data = (mdl_data / 2) + si * msb_w;
            end
        endcase
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        mdl_data = 0;
        mdl_so   = 0;
        checks++;
        if ({Data_Out, Shift_Out, Busy, Done} !== {8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got data=%h so=%b busy=%b done=%b, want 00/0/0/0",
                     Data_Out, Shift_Out, Busy, Done);
        end
    endtask

    task automatic do_load(input int val);
        Load = 1'b1;
        D    = WIDTH'(val);
        tick();
        Load = 1'b0;
        mdl_data = val & ((1 << WIDTH) - 1);
        checks++;
        if (Data_Out !== WIDTH'(mdl_data) || Busy !== 1'b0) begin
            errors++;
            $display("FAIL load: got data=%h busy=%b, want %h/0", Data_Out, Busy, WIDTH'(mdl_data));
        end
    endtask

    // Runs one sequence from an accepted Start; fsi < 0 means random Shift_In per cycle.
    // While busy/done, the other inputs are scrambled to prove they are ignored.
    task automatic run_seq(input shift_mode_t md, input int amt, input int fsi);
        int n;
        int si;
        n = (amt > WIDTH) ? WIDTH : amt;
        Start  = 1'b1;
        Mode   = md;
        Amount = CNT_W'(amt);
        tick();
        Start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            checks++;
            if (Busy !== 1'b1 || Done !== 1'b0) begin
                errors++;
                $display("FAIL busy_cycle%0d: got busy=%b done=%b, want 1/0", k, Busy, Done);
            end
            si       = (fsi < 0) ? int'($urandom_range(0, 1)) : fsi;
            Shift_In = si[0];
            Mode     = shift_mode_t'($urandom_range(0, 3));
            Amount   = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
            Load     = 1'($urandom_range(0, 1));
            Start    = 1'($urandom_range(0, 1));
            D        = WIDTH'($urandom);
            model_shift(md, si);
            tick();
        end
        Load  = 1'($urandom_range(0, 1));
        Start = 1'($urandom_range(0, 1));
        D     = WIDTH'($urandom);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b1 || Data_Out !== WIDTH'(mdl_data) ||
            Shift_Out !== 1'(mdl_so)) begin
            errors++;
            $display("FAIL done_cycle mode=%0d amt=%0d: got busy=%b done=%b data=%h so=%b, want 0/1/%h/%0d",
                     md, amt, Busy, Done, Data_Out, Shift_Out, WIDTH'(mdl_data), mdl_so);
        end
        tick();
        Load  = 1'b0;
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Data_Out !== WIDTH'(mdl_data)) begin
            errors++;
            $display("FAIL after_done: got busy=%b done=%b data=%h, want 0/0/%h",
                     Busy, Done, Data_Out, WIDTH'(mdl_data));
        end
    endtask

    task automatic test_directed();
        do_load(8'hB4);
        run_seq(LSR, 3, 0);
        checks++;
        if (Data_Out !== 8'h16 || Shift_Out !== 1'b1) begin
            errors++;
            $display("FAIL lsr3: got %h/%b, want 16/1", Data_Out, Shift_Out);
        end
        do_load(8'hB4);
        run_seq(ASR, 2, 1);
        checks++;
        if (Data_Out !== 8'hED || Shift_Out !== 1'b0) begin
            errors++;
            $display("FAIL asr2: got %h/%b, want ED/0", Data_Out, Shift_Out);
        end
        do_load(8'h81);
        run_seq(LSL, 1, 1);
        checks++;
        if (Data_Out !== 8'h03 || Shift_Out !== 1'b1) begin
            errors++;
            $display("FAIL lsl1: got %h/%b, want 03/1", Data_Out, Shift_Out);
        end
    endtask

    task automatic test_amount();
        do_load(8'hFF);
        run_seq(LSR, 12, 0);
        checks++;
        if (Data_Out !== 8'h00 || Shift_Out !== 1'b1) begin
            errors++;
            $display("FAIL clamp12: got %h/%b, want 00/1", Data_Out, Shift_Out);
        end
        do_load(8'hA7);
        run_seq(LSL, 0, 0);
        checks++;
        if (Data_Out !== 8'hA7 || Shift_Out !== 1'b1) begin
            errors++;
            $display("FAIL amount0: got %h/%b, want A7/1", Data_Out, Shift_Out);
        end
    endtask

    task automatic test_load_start_same();
        Load   = 1'b1;
        Start  = 1'b1;
        D      = 8'h3C;
        Mode   = LSR;
        Amount = CNT_W'(4);
        tick();
        Load  = 1'b0;
        Start = 1'b0;
        mdl_data = 8'h3C;
        checks++;
        if (Data_Out !== 8'h3C || Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL load_wins: got data=%h busy=%b done=%b, want 3C/0/0", Data_Out, Busy, Done);
        end
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL start_dropped: got busy=%b done=%b, want 0/0", Busy, Done);
        end
    endtask

    task automatic test_mid_reset();
        int done_seen;
        do_load(8'hC3);
        Start    = 1'b1;
        Mode     = LSR;
        Amount   = CNT_W'(5);
        Shift_In = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        mdl_data = 0;
        mdl_so   = 0;
        checks++;
        if ({Data_Out, Shift_Out, Busy, Done} !== {8'h00, 3'b000}) begin
            errors++;
            $display("FAIL mid_reset: got data=%h so=%b busy=%b done=%b, want 00/0/0/0",
                     Data_Out, Shift_Out, Busy, Done);
        end
        done_seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (Done === 1'b1 || Busy === 1'b1) done_seen++;
            tick();
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL aborted_done: got %0d busy/done cycles, want 0", done_seen);
        end
        run_seq(LSR, 1, 1);
        checks++;
        if (Data_Out !== 8'h80) begin
            errors++;
            $display("FAIL idle_after_reset: got %h, want 80", Data_Out);
        end
    endtask

    task automatic test_rotate();
        do_load(8'h01);
        run_seq(ROR, 1, 0);
        checks++;
`ifdef SHIFT_UNIT_ROTATE_EN
        if (Data_Out !== 8'h80 || Shift_Out !== 1'b1) begin
            errors++;
            $display("FAIL ror1: got %h/%b, want 80/1", Data_Out, Shift_Out);
        end
`else
        if (Data_Out !== 8'h00 || Shift_Out !== 1'b1) begin
            errors++;
            $display("FAIL ror1_as_lsr: got %h/%b, want 00/1", Data_Out, Shift_Out);
        end
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) do_load(int'($urandom_range(0, 255)));
            run_seq(shift_mode_t'($urandom_range(0, 3)), int'($urandom_range(0, (1 << CNT_W) - 1)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_amount();
        test_load_start_same();
        test_mid_reset();
        test_rotate();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_unit
